// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction-decode stage with register file, two-word
// immediate handling, load-use bubble insertion and a registered ID/EX
// output with valid/ready flow control.
// Optional macro: ID_BYPASS_EN -- write-to-read forwarding inside the
// register file (a same-cycle write is visible to the decode read).
module id_stage_pipe #(
    parameter int unsigned          WIDTH    = 16,
    parameter int unsigned          OPC_W    = 5,
    parameter int unsigned          NUM_REGS = 8,
    parameter int unsigned          ADDR_W   = 3,
    parameter logic [OPC_W-1:0]     LOAD_OPC = 5'b10100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_instr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              ex_stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    output logic              ex_valid,
    output logic [OPC_W-1:0]  ex_opcode,
    output logic [ADDR_W-1:0] ex_rs1,
    output logic [ADDR_W-1:0] ex_rs2,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [WIDTH-1:0]  ex_op1,
    output logic [WIDTH-1:0]  ex_op2,
    output logic [WIDTH-1:0]  ex_imm,
    output logic              ex_is_load
);

    typedef enum logic {
        DECODE   = 1'b0,
        WAIT_IMM = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  held_word;
    logic [WIDTH-1:0]  regs [NUM_REGS];

    // Fields of the incoming word (used for the hazard check and single-word decode)
    logic [OPC_W-1:0]  in_opc;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic              in_is_imm;

    // Word whose fields/operands go into ID/EX: the held first word in WAIT_IMM
    logic [WIDTH-1:0]  dec_word;
    logic [OPC_W-1:0]  dec_opc;
    logic [ADDR_W-1:0] dec_rs1;
    logic [ADDR_W-1:0] dec_rs2;
    logic [ADDR_W-1:0] dec_rd;
    logic [WIDTH-1:0]  dec_op1;
    logic [WIDTH-1:0]  dec_op2;

    logic              hazard;
    logic              accept;

    // Field extraction for the incoming word and for the word being decoded
    always_comb begin
        in_opc    = in_instr[WIDTH-1 -: OPC_W];
        in_rs1    = in_instr[WIDTH-OPC_W-1 -: ADDR_W];
        in_rs2    = in_instr[WIDTH-OPC_W-ADDR_W-1 -: ADDR_W];
        in_is_imm = (in_opc[OPC_W-1 -: 2] == 2'b11);

        dec_word  = (state == WAIT_IMM) ? held_word : in_instr;
        dec_opc   = dec_word[WIDTH-1 -: OPC_W];
        dec_rs1   = dec_word[WIDTH-OPC_W-1 -: ADDR_W];
        dec_rs2   = dec_word[WIDTH-OPC_W-ADDR_W-1 -: ADDR_W];
        dec_rd    = dec_word[WIDTH-OPC_W-2*ADDR_W-1 -: ADDR_W];
    end

    // Combinational register-file reads of the decoded source registers
    always_comb begin
`ifdef ID_BYPASS_EN
        dec_op1 = (wb_en && (wb_addr == dec_rs1)) ? wb_data : regs[dec_rs1];
        dec_op2 = (wb_en && (wb_addr == dec_rs2)) ? wb_data : regs[dec_rs2];
`else
        dec_op1 = regs[dec_rs1];
        dec_op2 = regs[dec_rs2];
`endif
    end

    // Load-use hazard detection and input handshake
    always_comb begin
        hazard   = (state == DECODE) && in_valid && ex_valid && ex_is_load &&
                   ((ex_rd == in_rs1) || (ex_rd == in_rs2));
        in_ready = rst && !flush && !ex_stall && !hazard;
        accept   = in_valid && in_ready;
    end

    // Next-state logic: flush > stall > hazard > normal
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = DECODE;
        end else if (!ex_stall && !hazard && accept) begin
            case (state)
                DECODE:   state_nxt = in_is_imm ? WAIT_IMM : DECODE;
                WAIT_IMM: state_nxt = DECODE;
                default:  state_nxt = DECODE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DECODE;
        end else begin
            state <= state_nxt;
        end
    end

    // Held first word of an immediate-class pair; dropped on flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_word <= '0;
        end else if (flush) begin
            held_word <= '0;
        end else if (!ex_stall && accept && (state == DECODE) && in_is_imm) begin
            held_word <= in_instr;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid   <= 1'b0;
            ex_opcode  <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_op1     <= '0;
            ex_op2     <= '0;
            ex_imm     <= '0;
            ex_is_load <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_stall) begin
            ex_valid <= ex_valid;
        end else if (!accept || ((state == DECODE) && in_is_imm)) begin
            // hazard bubble, idle cycle, or first word of an immediate pair
            ex_valid <= 1'b0;
        end else begin
            ex_valid   <= 1'b1;
            ex_opcode  <= dec_opc;
            ex_rs1     <= dec_rs1;
            ex_rs2     <= dec_rs2;
            ex_rd      <= dec_rd;
            ex_op1     <= dec_op1;
            ex_op2     <= dec_op2;
            ex_imm     <= in_instr;
            ex_is_load <= (dec_opc == LOAD_OPC);
        end
    end

    // Register file write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '{default: '0};
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed testbench for id_stage_pipe: reset, register reads, immediate
// pairs, load-use bubbles, stall/flush and same-cycle write/read.
module tb_id_stage_pipe;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned OPC_W  = 5;
    localparam int unsigned ADDR_W = 3;
    localparam logic [4:0]  LOAD   = 5'b10100;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  in_instr;
    logic              in_valid;
    logic              in_ready;
    logic              ex_stall;
    logic              flush;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [WIDTH-1:0]  wb_data;
    logic              ex_valid;
    logic [OPC_W-1:0]  ex_opcode;
    logic [ADDR_W-1:0] ex_rs1;
    logic [ADDR_W-1:0] ex_rs2;
    logic [ADDR_W-1:0] ex_rd;
    logic [WIDTH-1:0]  ex_op1;
    logic [WIDTH-1:0]  ex_op2;
    logic [WIDTH-1:0]  ex_imm;
    logic              ex_is_load;

    int errors = 0;
    int checks = 0;

    id_stage_pipe #(
        .WIDTH    (16),
        .OPC_W    (5),
        .NUM_REGS (8),
        .ADDR_W   (3),
        .LOAD_OPC (5'b10100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_instr   (in_instr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ex_stall   (ex_stall),
        .flush      (flush),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_rd      (ex_rd),
        .ex_op1     (ex_op1),
        .ex_op2     (ex_op2),
        .ex_imm     (ex_imm),
        .ex_is_load (ex_is_load)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [4:0] opc, input logic [2:0] s1,
                                       input logic [2:0] s2, input logic [2:0] d);
        return {opc, s1, s2, d, 2'b00};
    endfunction

    // advance one clock; inputs are driven and outputs sampled 2 time units after the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_instr = '0; ex_stall = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b expected 0", ex_valid); end
        checks++; if (ex_imm !== 16'h0000) begin errors++; $display("FAIL reset_ex_imm: got %h expected 0000", ex_imm); end
        step(); step();
        rst = 1'b1;
        // write r1 so the reset of the register file is observable
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h1111;
        step();
        wb_en = 1'b0;
        // enter WAIT_IMM
        in_valid = 1'b1; in_instr = mk(5'b11000, 3'd1, 3'd1, 3'd1);
        step();
        in_valid = 1'b0;
        // async reset in the middle of the cycle
        rst = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid: got %b expected 0", ex_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_ready: got %b expected 0", in_ready); end
        #2;
        rst = 1'b1;
        step();
        // DECODE after reset: a single-word instruction decodes itself, r1 reads zero
        in_valid = 1'b1; in_instr = mk(5'b00001, 3'd1, 3'd1, 3'd0);
        step();
        in_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL reset_state_valid: got %b expected 1", ex_valid); end
        checks++; if (ex_opcode !== 5'b00001) begin errors++; $display("FAIL reset_state_opc: got %b expected 00001", ex_opcode); end
        checks++; if (ex_op1 !== 16'h0000) begin errors++; $display("FAIL reset_regs: got %h expected 0000", ex_op1); end
        step();
    endtask

    task automatic test_regread();
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h00A5;
        step();
        wb_addr = 3'd5; wb_data = 16'h0F0F;
        step();
        wb_en = 1'b0;
        in_valid = 1'b1; in_instr = mk(5'b00001, 3'd3, 3'd5, 3'd0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rd_valid: got %b expected 1", ex_valid); end
        checks++; if (ex_op1 !== 16'h00A5) begin errors++; $display("FAIL rd_op1: got %h expected 00a5", ex_op1); end
        checks++; if (ex_op2 !== 16'h0F0F) begin errors++; $display("FAIL rd_op2: got %h expected 0f0f", ex_op2); end
        checks++; if (ex_rs2 !== 3'd5) begin errors++; $display("FAIL rd_rs2: got %0d expected 5", ex_rs2); end
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rd_idle: got %b expected 0", ex_valid); end
    endtask

    task automatic test_imm();
        in_valid = 1'b1; in_instr = mk(5'b11000, 3'd3, 3'd5, 3'd6);
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL imm_bubble: got %b expected 0", ex_valid); end
        in_instr = 16'h1234;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL imm_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL imm_valid: got %b expected 1", ex_valid); end
        checks++; if (ex_imm !== 16'h1234) begin errors++; $display("FAIL imm_value: got %h expected 1234", ex_imm); end
        checks++; if (ex_opcode !== 5'b11000) begin errors++; $display("FAIL imm_opc: got %b expected 11000", ex_opcode); end
        checks++; if (ex_op1 !== 16'h00A5) begin errors++; $display("FAIL imm_op1: got %h expected 00a5", ex_op1); end
        checks++; if (ex_rd !== 3'd6) begin errors++; $display("FAIL imm_rd: got %0d expected 6", ex_rd); end
        step();
    endtask

    task automatic test_load_use();
        // independent follower: no bubble
        in_valid = 1'b1; in_instr = mk(LOAD, 3'd0, 3'd0, 3'd2);
        step();
        checks++; if (ex_is_load !== 1'b1) begin errors++; $display("FAIL lu_is_load: got %b expected 1", ex_is_load); end
        in_instr = mk(5'b00001, 3'd3, 3'd5, 3'd0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_indep_ready: got %b expected 1", in_ready); end
        step();
        // dependent follower
        in_instr = mk(LOAD, 3'd0, 3'd0, 3'd2);
        step();
        in_instr = mk(5'b00001, 3'd2, 3'd0, 3'd0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_ready: got %b expected 0", in_ready); end
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %b expected 0", ex_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_rs1 !== 3'd2 || ex_opcode !== 5'b00001) begin
            errors++; $display("FAIL lu_accept: got v=%b rs1=%0d opc=%b expected v=1 rs1=2 opc=00001", ex_valid, ex_rs1, ex_opcode);
        end
        step();
    endtask

    task automatic test_stall_flush();
        in_valid = 1'b1; in_instr = mk(5'b00001, 3'd3, 3'd5, 3'd7);
        step();
        ex_stall = 1'b1; in_instr = mk(5'b00010, 3'd5, 3'd3, 3'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b expected 0", i, in_ready); end
            step();
            checks++; if (ex_valid !== 1'b1 || ex_opcode !== 5'b00001 || ex_rd !== 3'd7 || ex_op1 !== 16'h00A5) begin
                errors++; $display("FAIL stall_hold%0d: got v=%b opc=%b rd=%0d op1=%h expected v=1 opc=00001 rd=7 op1=00a5", i, ex_valid, ex_opcode, ex_rd, ex_op1);
            end
        end
        ex_stall = 1'b0;
        step();
        checks++; if (ex_opcode !== 5'b00010) begin errors++; $display("FAIL stall_resume: got %b expected 00010", ex_opcode); end
        // flush while waiting for the immediate
        in_instr = mk(5'b11000, 3'd3, 3'd5, 3'd6);
        step();
        flush = 1'b1; in_instr = 16'h5678;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
        step();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", ex_valid); end
        in_instr = mk(5'b00001, 3'd5, 3'd3, 3'd4);
        step();
        in_valid = 1'b0;
        checks++; if (ex_valid !== 1'b1 || ex_opcode !== 5'b00001 || ex_imm !== mk(5'b00001, 3'd5, 3'd3, 3'd4)) begin
            errors++; $display("FAIL flush_decode: got v=%b opc=%b imm=%h expected v=1 opc=00001 imm=%h", ex_valid, ex_opcode, ex_imm, mk(5'b00001, 3'd5, 3'd3, 3'd4));
        end
        step();
    endtask

    task automatic test_bypass();
        logic [15:0] exp_same;
`ifdef ID_BYPASS_EN
        exp_same = 16'hBEEF;
`else
        exp_same = 16'h0000;
`endif
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'hBEEF;
        in_valid = 1'b1; in_instr = mk(5'b00001, 3'd4, 3'd0, 3'd0);
        step();
        wb_en = 1'b0;
        checks++; if (ex_op1 !== exp_same) begin errors++; $display("FAIL bypass_same: got %h expected %h", ex_op1, exp_same); end
        step();
        in_valid = 1'b0;
        checks++; if (ex_op1 !== 16'hBEEF) begin errors++; $display("FAIL bypass_next: got %h expected beef", ex_op1); end
        step();
    endtask

    initial begin
        test_reset();
        test_regread();
        test_imm();
        test_load_use();
        test_stall_flush();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
